// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of one SRAM controller: port 0 has fixed priority, reads return in order.
// Build option SRAM_PORT_ARBITER_STARVE_EN forces a port-1 grant after MAX_STARVE back-to-back port-0 wins.
module sram_port_arbiter #(
  parameter int ADDR_BITS  = 20,
  parameter int DATA_BITS  = 16,
  parameter int RD_DEPTH   = 4,
  parameter int MAX_STARVE = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic                 s0_valid,
  output logic                 s0_ready,
  input  logic                 s0_we,
  input  logic [ADDR_BITS-1:0] s0_addr,
  input  logic [DATA_BITS-1:0] s0_wdata,
  output logic                 s0_rvalid,
  output logic [DATA_BITS-1:0] s0_rdata,

  input  logic                 s1_valid,
  output logic                 s1_ready,
  input  logic                 s1_we,
  input  logic [ADDR_BITS-1:0] s1_addr,
  input  logic [DATA_BITS-1:0] s1_wdata,
  output logic                 s1_rvalid,
  output logic [DATA_BITS-1:0] s1_rdata,

  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_we,
  output logic [ADDR_BITS-1:0] m_addr,
  output logic [DATA_BITS-1:0] m_wdata,
  input  logic                 m_rvalid,
  input  logic [DATA_BITS-1:0] m_rdata,

  output logic                 rsp_err
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high; once
  // valid is raised its payload stays stable until that edge, and ready never waits on the
  // partner's valid except through the port-0/port-1 winner selection.

  localparam int PTR_W = $clog2(RD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(RD_DEPTH);

  logic                 slot_free;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 elig0;
  logic                 elig1;
  logic                 win0;
  logic                 win1;
  logic                 p1_forced;
  logic                 acc0;
  logic                 acc1;
  logic                 acc_any;
  logic                 acc_we;
  logic [ADDR_BITS-1:0] acc_addr;
  logic [DATA_BITS-1:0] acc_wdata;

  logic                 push;
  logic                 pop;
  logic                 push_id;
  logic                 head_id;
  logic                 id_mem [RD_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     rd_count;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign slot_free  = !m_valid || m_ready;
  assign fifo_full  = (rd_count == FIFO_FULL_CNT);
  assign fifo_empty = (rd_count == '0);

  // A read is only eligible while an ID slot is free; writes never wait on the FIFO.
  assign elig0 = s0_valid && (s0_we || !fifo_full);
  assign elig1 = s1_valid && (s1_we || !fifo_full);

  always_comb begin
    win0 = elig0 && !p1_forced;
    win1 = elig1 && !win0;
  end

  // Ready is held low while reset is asserted so every output reads 0 immediately.
  assign s0_ready = reset_n && slot_free && win0;
  assign s1_ready = reset_n && slot_free && win1;

  assign acc0    = s0_valid && s0_ready;
  assign acc1    = s1_valid && s1_ready;
  assign acc_any = acc0 || acc1;

  always_comb begin
    acc_we    = s0_we;
    acc_addr  = s0_addr;
    acc_wdata = s0_wdata;
    if (acc1) begin
      acc_we    = s1_we;
      acc_addr  = s1_addr;
      acc_wdata = s1_wdata;
    end
  end

`ifdef SRAM_PORT_ARBITER_STARVE_EN
  localparam int STARVE_W = $clog2(MAX_STARVE + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(MAX_STARVE);

  logic [STARVE_W-1:0] starve_cnt;

  assign p1_forced = elig1 && (starve_cnt == STARVE_LIMIT);

  // Counts port-0 wins that port 1 sat through; any pause in port-1 demand forgives the debt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!elig1 || acc1) begin
      starve_cnt <= '0;
    end else if (acc0 && (starve_cnt != STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_starve_cfg;

  assign p1_forced         = 1'b0;
  assign unused_starve_cfg = MAX_STARVE;
`endif

  // ---------------------------------------------------------------------------
  // Command slot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (slot_free) begin
      m_valid <= acc_any;
      if (acc_any) begin
        m_we    <= acc_we;
        m_addr  <= acc_addr;
        m_wdata <= acc_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ID FIFO: pushed at accept so the order matches the command stream downstream
  // ---------------------------------------------------------------------------
  assign push    = (acc0 && !s0_we) || (acc1 && !s1_we);
  assign push_id = acc1;
  assign pop     = m_rvalid && !fifo_empty;
  assign head_id = id_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   rd_count <= rd_count + 1'b1;
        2'b01:   rd_count <= rd_count - 1'b1;
        default: rd_count <= rd_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_rvalid <= 1'b0;
      s1_rvalid <= 1'b0;
      s0_rdata  <= '0;
      s1_rdata  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      s0_rvalid <= pop && !head_id;
      s1_rvalid <= pop && head_id;
      if (pop && !head_id) begin
        s0_rdata <= m_rdata;
      end
      if (pop && head_id) begin
        s1_rdata <= m_rdata;
      end
      // Data with no matching request is dropped; the flag stays up until reset.
      if (m_rvalid && fifo_empty) begin
        rsp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with command and response scoreboards.
module tb_sram_port_arbiter;

  localparam int ADDR_BITS  = 20;
  localparam int DATA_BITS  = 16;
  localparam int RD_DEPTH   = 4;
  localparam int MAX_STARVE = 8;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 s0_valid, s0_ready, s0_we, s0_rvalid;
  logic [ADDR_BITS-1:0] s0_addr;
  logic [DATA_BITS-1:0] s0_wdata, s0_rdata;
  logic                 s1_valid, s1_ready, s1_we, s1_rvalid;
  logic [ADDR_BITS-1:0] s1_addr;
  logic [DATA_BITS-1:0] s1_wdata, s1_rdata;
  logic                 m_valid, m_ready, m_we, m_rvalid;
  logic [ADDR_BITS-1:0] m_addr;
  logic [DATA_BITS-1:0] m_wdata, m_rdata;
  logic                 rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [36:0] exp_cmd_q[$];
  logic [17:0] exp_rsp_q[$];
  int          rd_order[$];
  logic [36:0] cmd_got;
  logic [17:0] rsp_got;

  sram_port_arbiter #(
    .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .RD_DEPTH(RD_DEPTH), .MAX_STARVE(MAX_STARVE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_we(s0_we), .s0_addr(s0_addr),
    .s0_wdata(s0_wdata), .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_we(s1_we), .s1_addr(s1_addr),
    .s1_wdata(s1_wdata), .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .rsp_err(rsp_err)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checker and drivers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int port, input logic we, input logic [ADDR_BITS-1:0] addr,
                       input logic [DATA_BITS-1:0] wdata);
    int   waited;
    logic rdy;
    waited = 0;
    if (port == 0) begin
      s0_valid = 1'b1; s0_we = we; s0_addr = addr; s0_wdata = wdata;
    end else begin
      s1_valid = 1'b1; s1_we = we; s1_addr = addr; s1_wdata = wdata;
    end
    @(negedge clk);
    rdy = (port == 0) ? s0_ready : s1_ready;
    while (!rdy && waited < 50) begin
      @(negedge clk);
      waited++;
      rdy = (port == 0) ? s0_ready : s1_ready;
    end
    check($sformatf("issue_p%0d_accept", port), 64'(rdy), 64'd1);
    if (rdy) begin
      exp_cmd_q.push_back({we, addr, wdata});
      if (!we) rd_order.push_back(port);
    end
    @(posedge clk);
    #1;
    if (port == 0) s0_valid = 1'b0;
    else           s1_valid = 1'b0;
  endtask

  task automatic respond(input logic [DATA_BITS-1:0] data);
    int p;
    if (rd_order.size() > 0) begin
      p = rd_order.pop_front();
      exp_rsp_q.push_back({p == 1, p == 0, data});
    end
    m_rvalid = 1'b1;
    m_rdata  = data;
    @(posedge clk);
    #1;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  task automatic drain(input string tag);
    cyc(3);
    check({tag, "_cmd_left"}, 64'(exp_cmd_q.size()), 64'd0);
    check({tag, "_rsp_left"}, 64'(exp_rsp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitors (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (s0_rvalid || s1_rvalid) begin
        rsp_got = {s1_rvalid, s0_rvalid, (s1_rvalid ? s1_rdata : s0_rdata)};
        if (exp_rsp_q.size() == 0) check("rsp_unexpected", 64'(rsp_got), 64'd0);
        else                       check("rsp", 64'(rsp_got), 64'(exp_rsp_q.pop_front()));
      end
      if (m_valid && m_ready) begin
        cmd_got = {m_we, m_addr, m_wdata};
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", 64'(cmd_got), 64'd0);
        else                       check("cmd", 64'(cmd_got), 64'(exp_cmd_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic exp1;
`ifdef SRAM_PORT_ARBITER_STARVE_EN
  int scnt;
`endif

  initial begin
    s0_valid = 1'b1; s0_we = 1'b1; s0_addr = '0; s0_wdata = '0;
    s1_valid = 1'b1; s1_we = 1'b1; s1_addr = '0; s1_wdata = '0;
    m_ready = 1'b1; m_rvalid = 1'b0; m_rdata = '0;

    // Reset held: outputs quiet even with requests pending
    #12;
    check("rst_s0_ready", 64'(s0_ready), 64'd0);
    check("rst_s1_ready", 64'(s1_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rvalid", 64'({s1_rvalid, s0_rvalid}), 64'd0);
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(1);

    // Single read on port 0
    issue(0, 1'b0, 20'h00010, 16'h0000);
    cyc(1);
    respond(16'hBEEF);
    drain("single_read");
    check("single_err", 64'(rsp_err), 64'd0);

    // Both ports request every cycle
    s0_valid = 1'b1; s0_we = 1'b1; s0_addr = 20'h00100; s0_wdata = 16'h0A0A;
    s1_valid = 1'b1; s1_we = 1'b1; s1_addr = 20'h00200; s1_wdata = 16'h1B1B;
`ifdef SRAM_PORT_ARBITER_STARVE_EN
    scnt = 0;
`endif
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
`ifdef SRAM_PORT_ARBITER_STARVE_EN
      exp1 = (scnt == MAX_STARVE);
      scnt = exp1 ? 0 : scnt + 1;
`else
      exp1 = 1'b0;
`endif
      check($sformatf("prio_s0_ready_%0d", i), 64'(s0_ready), 64'(!exp1));
      check($sformatf("prio_s1_ready_%0d", i), 64'(s1_ready), 64'(exp1));
      exp_cmd_q.push_back(exp1 ? {1'b1, 20'h00200, 16'h1B1B} : {1'b1, 20'h00100, 16'h0A0A});
      @(posedge clk); #1;
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    drain("prio");

    // Controller back-pressure holds the slot
    m_ready = 1'b0;
    issue(0, 1'b1, 20'h0ABCD, 16'h5A5A);
    s0_valid = 1'b1; s0_we = 1'b1; s0_addr = 20'h0ABCE; s0_wdata = 16'hC3C3;
    s1_valid = 1'b1; s1_we = 1'b1; s1_addr = 20'h00300; s1_wdata = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_m_valid_%0d", i), 64'(m_valid), 64'd1);
      check($sformatf("stall_m_addr_%0d", i), 64'(m_addr), 64'h0ABCD);
      check($sformatf("stall_m_wdata_%0d", i), 64'(m_wdata), 64'h5A5A);
      check($sformatf("stall_ready_%0d", i), 64'({s1_ready, s0_ready}), 64'd0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", 64'({s1_ready, s0_ready}), 64'b01);
    exp_cmd_q.push_back({1'b1, 20'h0ABCE, 16'hC3C3});
    @(posedge clk); #1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    drain("stall");

    // Fill the read FIFO, then a write must still pass a stalled read
    issue(0, 1'b0, 20'h01000, 16'h0000);
    issue(1, 1'b0, 20'h02000, 16'h0000);
    issue(0, 1'b0, 20'h01001, 16'h0000);
    issue(1, 1'b0, 20'h02001, 16'h0000);
    cyc(2);
    s0_valid = 1'b1; s0_we = 1'b0; s0_addr = 20'h01002; s0_wdata = 16'h0000;
    s1_valid = 1'b1; s1_we = 1'b1; s1_addr = 20'h03000; s1_wdata = 16'h1234;
    @(negedge clk);
    check("full_s0_read_stalled", 64'(s0_ready), 64'd0);
    check("full_s1_write_granted", 64'(s1_ready), 64'd1);
    exp_cmd_q.push_back({1'b1, 20'h03000, 16'h1234});
    @(posedge clk); #1;
    s1_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("full_s0_still_stalled_%0d", i), 64'(s0_ready), 64'd0);
      @(posedge clk); #1;
    end
    s0_valid = 1'b0;
    respond(16'hA000);
    respond(16'hA001);
    respond(16'hA002);
    respond(16'hA003);
    drain("full");
    issue(0, 1'b0, 20'h01002, 16'h0000);
    cyc(1);
    respond(16'hA004);
    drain("after_full");
    check("full_err", 64'(rsp_err), 64'd0);

    // Response with nothing outstanding
    respond(16'hDEAD);
    cyc(2);
    check("orphan_err_set", 64'(rsp_err), 64'd1);
    cyc(5);
    check("orphan_err_sticky", 64'(rsp_err), 64'd1);
    check("orphan_rsp_left", 64'(exp_rsp_q.size()), 64'd0);

    // Reset in the middle of a stalled command with a read outstanding
    m_ready = 1'b0;
    issue(0, 1'b0, 20'h04000, 16'h0000);
    s0_valid = 1'b1; s0_we = 1'b1; s0_addr = 20'h05000; s0_wdata = 16'h5555;
    s1_valid = 1'b1; s1_we = 1'b1; s1_addr = 20'h06000; s1_wdata = 16'h6666;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_m_cmd", 64'({m_we, m_addr, m_wdata}), 64'd0);
    check("midrst_ready", 64'({s1_ready, s0_ready}), 64'd0);
    check("midrst_rvalid", 64'({s1_rvalid, s0_rvalid}), 64'd0);
    check("midrst_rdata", 64'({s1_rdata, s0_rdata}), 64'd0);
    check("midrst_rsp_err", 64'(rsp_err), 64'd0);
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    rd_order.delete();
    s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
    cyc(2);
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_m_valid", 64'(m_valid), 64'd0);
    check("postrst_rsp_err", 64'(rsp_err), 64'd0);
    @(posedge clk); #1;
    // The pre-reset read ID must be gone, so this response is an orphan
    respond(16'hBAD0);
    cyc(2);
    check("postrst_orphan_err", 64'(rsp_err), 64'd1);
    drain("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
